// File: rtl/croc_obi_reg_bridge.sv
// croc_obi_reg_bridge: single-outstanding OBI subordinate to regbus manager bridge with watchdog.
module croc_obi_reg_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 3,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    input  logic [IdWidth-1:0]     obi_aid_i,
    output logic                   obi_rvalid_o,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic [IdWidth-1:0]     obi_rid_o,
    output logic                   obi_err_o,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic                   reg_write_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    output logic                   reg_valid_o,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i,
    input  logic                   reg_ready_i,
    output logic                   timeout_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q;
    logic [IdWidth-1:0] aid_q;
    logic done, expire;
    assign obi_gnt_o = obi_req_i && (state_q != ACCESS);
    assign done      = (state_q == ACCESS) && reg_ready_i;
    assign expire    = (state_q == ACCESS) && !reg_ready_i && (cnt_q == 16'(TimeoutCycles - 1));
    always_comb begin
        state_d = IDLE;
        if (obi_gnt_o)
            state_d = ACCESS;
        else if (state_q == ACCESS)
            state_d = (done || expire) ? RESP : ACCESS;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end
    // The regbus outputs double as the request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            aid_q        <= '0;
            reg_addr_o   <= '0;
            reg_write_o  <= 1'b0;
            reg_wdata_o  <= '0;
            reg_wstrb_o  <= '0;
            reg_valid_o  <= 1'b0;
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_rid_o    <= '0;
            obi_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            obi_rvalid_o <= done || expire;
            timeout_o    <= expire;
            if (obi_gnt_o) begin
                reg_addr_o  <= obi_addr_i;
                reg_write_o <= obi_we_i;
                reg_wdata_o <= obi_wdata_i;
                reg_wstrb_o <= obi_be_i;
                aid_q       <= obi_aid_i;
                reg_valid_o <= 1'b1;
                cnt_q       <= '0;
            end else if (done || expire) begin
                reg_valid_o <= 1'b0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (done || expire) begin
                obi_rdata_o <= (expire || reg_write_o) ? '0 : reg_rdata_i;
                obi_err_o   <= expire || reg_error_i;
                obi_rid_o   <= aid_q;
            end
        end
    end
endmodule
